// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and sequencer in front of a single-port
// synchronous data memory, with alignment and range checking.
module dmem_arbiter #(
    parameter int MEM_WORDS  = 64,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ0,
    input  logic        REQ1,
    input  logic [31:0] ADDR0,
    input  logic [31:0] ADDR1,
    input  logic        WE0,
    input  logic        WE1,
    input  logic [1:0]  LEN0,
    input  logic [1:0]  LEN1,
    input  logic [31:0] WDATA0,
    input  logic [31:0] WDATA1,
    output logic        GNT0,
    output logic        GNT1,
    output logic        RVALID0,
    output logic        RVALID1,
    output logic [31:0] RDATA,
    output logic        RERR,
    output logic [31:0] MEM_A,
    output logic        MEM_WE,
    output logic [1:0]  MEM_LEN,
    output logic [31:0] MEM_WD,
    input  logic [31:0] MEM_RD
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t      state;
    logic        last_owner;
    logic        owner;
    logic        own_we;
    logic        own_err;

    logic        win1;
    logic        sel_we;
    logic        sel_err;
    logic [1:0]  sel_len;
    logic [31:0] sel_addr;
    logic [31:0] sel_wd;

    always_comb begin
        if (FIXED_PRIO) win1 = REQ1 && !REQ0;
        else            win1 = REQ1 && (!REQ0 || !last_owner);
    end

    always_comb begin
        sel_addr = win1 ? ADDR1  : ADDR0;
        sel_we   = win1 ? WE1    : WE0;
        sel_len  = win1 ? LEN1   : LEN0;
        sel_wd   = win1 ? WDATA1 : WDATA0;
    end

    always_comb begin
        sel_err = 1'b0;
        unique case (sel_len)
            2'b01:        sel_err = sel_addr[0];
            2'b10, 2'b11: sel_err = |sel_addr[1:0];
            default:      sel_err = 1'b0;
        endcase
        if ({2'b00, sel_addr[31:2]} >= 32'(MEM_WORDS)) sel_err = 1'b1;
    end

    // Load data arrives from memory during RESP, so it cannot be registered.
    assign RDATA = (state == RESP && !own_we && !own_err) ? MEM_RD : '0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            owner      <= 1'b0;
            own_we     <= 1'b0;
            own_err    <= 1'b0;
            GNT0       <= 1'b0;
            GNT1       <= 1'b0;
            RVALID0    <= 1'b0;
            RVALID1    <= 1'b0;
            RERR       <= 1'b0;
            MEM_A      <= '0;
            MEM_WE     <= 1'b0;
            MEM_LEN    <= '0;
            MEM_WD     <= '0;
        end else begin
            GNT0    <= 1'b0;
            GNT1    <= 1'b0;
            RVALID0 <= 1'b0;
            RVALID1 <= 1'b0;
            RERR    <= 1'b0;
            MEM_WE  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (REQ0 || REQ1) begin
                        owner      <= win1;
                        last_owner <= win1;
                        own_we     <= sel_we;
                        own_err    <= sel_err;
                        MEM_A      <= sel_addr;
                        MEM_LEN    <= sel_len;
                        MEM_WD     <= sel_wd;
                        MEM_WE     <= sel_we && !sel_err;
                        GNT0       <= !win1;
                        GNT1       <= win1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    RVALID0 <= !owner;
                    RVALID1 <= owner;
                    RERR    <= own_err;
                    state   <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed checks of dmem_arbiter against
// a transaction-level reference model and a behavioural memory.
module tb_dmem_arbiter;

    logic        CLK;
    logic        RST_N;
    logic        REQ0, REQ1;
    logic [31:0] ADDR0, ADDR1;
    logic        WE0, WE1;
    logic [1:0]  LEN0, LEN1;
    logic [31:0] WDATA0, WDATA1;
    logic        GNT0, GNT1, RVALID0, RVALID1, RERR, MEM_WE;
    logic [31:0] RDATA, MEM_A, MEM_WD, MEM_RD;
    logic [1:0]  MEM_LEN;

    logic        fp_gnt0, fp_gnt1, fp_rvalid0, fp_rvalid1, fp_rerr, fp_we;
    logic [31:0] fp_rdata, fp_a, fp_wd;
    logic [1:0]  fp_len;

    int          tests;
    int          fails;
    int          we_cnt;
    logic        mem_clr;
    logic [31:0] mem [0:63];
    logic [31:0] ref_mem [0:63];

    dmem_arbiter #(.MEM_WORDS(64), .FIXED_PRIO(1'b0)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ0(REQ0), .REQ1(REQ1),
        .ADDR0(ADDR0), .ADDR1(ADDR1),
        .WE0(WE0), .WE1(WE1),
        .LEN0(LEN0), .LEN1(LEN1),
        .WDATA0(WDATA0), .WDATA1(WDATA1),
        .GNT0(GNT0), .GNT1(GNT1),
        .RVALID0(RVALID0), .RVALID1(RVALID1),
        .RDATA(RDATA), .RERR(RERR),
        .MEM_A(MEM_A), .MEM_WE(MEM_WE),
        .MEM_LEN(MEM_LEN), .MEM_WD(MEM_WD),
        .MEM_RD(MEM_RD)
    );

    dmem_arbiter #(.MEM_WORDS(64), .FIXED_PRIO(1'b1)) dut_fp (
        .CLK(CLK), .RST_N(RST_N),
        .REQ0(REQ0), .REQ1(REQ1),
        .ADDR0(ADDR0), .ADDR1(ADDR1),
        .WE0(WE0), .WE1(WE1),
        .LEN0(LEN0), .LEN1(LEN1),
        .WDATA0(WDATA0), .WDATA1(WDATA1),
        .GNT0(fp_gnt0), .GNT1(fp_gnt1),
        .RVALID0(fp_rvalid0), .RVALID1(fp_rvalid1),
        .RDATA(fp_rdata), .RERR(fp_rerr),
        .MEM_A(fp_a), .MEM_WE(fp_we),
        .MEM_LEN(fp_len), .MEM_WD(fp_wd),
        .MEM_RD(32'h0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] merge(input logic [31:0] w, input int lane,
                                          input logic [1:0] len, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        case (len)
            2'b00:   r[lane*8 +: 8] = d[7:0];
            2'b01:   r[(lane/2)*16 +: 16] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rd_ext(input logic [31:0] w, input int lane,
                                           input logic [1:0] len);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[lane*8 +: 8];
        h = w[(lane/2)*16 +: 16];
        case (len)
            2'b00:   r = {{24{b[7]}}, b};
            2'b01:   r = {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Single-port memory: one-cycle read latency, write on the clock edge.
    always @(posedge CLK) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        end else if (MEM_WE) begin
            mem[MEM_A[7:2]] <= merge(mem[MEM_A[7:2]], int'(MEM_A[1:0]), MEM_LEN, MEM_WD);
        end
        MEM_RD <= rd_ext(mem[MEM_A[7:2]], int'(MEM_A[1:0]), MEM_LEN);
    end

    always @(negedge CLK) begin
        if (MEM_WE) we_cnt <= we_cnt + 1;
    end

    task automatic drop_reqs();
        REQ0 = 1'b0;
        REQ1 = 1'b0;
    endtask

    task automatic test_reset();
        drop_reqs();
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        tests++;
        if ({GNT0, GNT1, RVALID0, RVALID1, RERR, MEM_WE} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl got %b want 000000",
                     {GNT0, GNT1, RVALID0, RVALID1, RERR, MEM_WE});
        end
        tests++;
        if (RDATA !== 32'h0 || MEM_A !== 32'h0 || MEM_LEN !== 2'b0 || MEM_WD !== 32'h0) begin
            fails++;
            $display("FAIL reset_data rdata=%h a=%h len=%b wd=%h want all 0",
                     RDATA, MEM_A, MEM_LEN, MEM_WD);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    // Starts and ends in IDLE, #1 after a rising edge.
    task automatic do_access(input int port, input logic [31:0] addr, input logic we,
                             input logic [1:0] len, input logic [31:0] wd);
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [1:0]  exp_g;
        int          widx;
        int          lane;
        int          c0;
        widx    = int'(addr[7:2]);
        lane    = int'(addr % 4);
        exp_err = (len == 2'b01 && addr % 2 != 0) ||
                  (len >= 2'b10 && addr % 4 != 0) ||
                  ((addr / 4) >= 32'd64);
        exp_rd  = 32'h0;
        if (!exp_err) begin
            if (we) ref_mem[widx] = merge(ref_mem[widx], lane, len, wd);
            else    exp_rd = rd_ext(ref_mem[widx], lane, len);
        end
        exp_g = (port == 0) ? 2'b01 : 2'b10;
        c0    = we_cnt;
        if (port == 0) begin
            REQ0 = 1'b1; ADDR0 = addr; WE0 = we; LEN0 = len; WDATA0 = wd;
        end else begin
            REQ1 = 1'b1; ADDR1 = addr; WE1 = we; LEN1 = len; WDATA1 = wd;
        end
        @(posedge CLK);
        #1;
        tests++;
        if ({GNT1, GNT0} !== exp_g) begin
            fails++;
            $display("FAIL gnt port%0d a=%h got %b want %b", port, addr, {GNT1, GNT0}, exp_g);
        end
        tests++;
        if (MEM_WE !== (we && !exp_err) || MEM_A !== addr) begin
            fails++;
            $display("FAIL issue a=%h we got %b want %b mem_a %h",
                     addr, MEM_WE, we && !exp_err, MEM_A);
        end
        drop_reqs();
        @(posedge CLK);
        #1;
        tests++;
        if ({RVALID1, RVALID0} !== exp_g || RERR !== exp_err) begin
            fails++;
            $display("FAIL resp a=%h rvalid=%b rerr=%b want %b %b",
                     addr, {RVALID1, RVALID0}, RERR, exp_g, exp_err);
        end
        tests++;
        if (RDATA !== exp_rd) begin
            fails++;
            $display("FAIL rdata a=%h len=%b got %h want %h", addr, len, RDATA, exp_rd);
        end
        @(posedge CLK);
        #1;
        tests++;
        if ({GNT0, GNT1, RVALID0, RVALID1, RERR} !== 5'b0 ||
            (we_cnt - c0) != ((we && !exp_err) ? 1 : 0)) begin
            fails++;
            $display("FAIL post a=%h ctrl=%b we_pulses got %0d want %0d", addr,
                     {GNT0, GNT1, RVALID0, RVALID1, RERR}, we_cnt - c0,
                     (we && !exp_err) ? 1 : 0);
        end
    endtask

    task automatic test_store_load();
        do_access(0, 32'h10, 1'b1, 2'b10, 32'hDEADBEEF);
        do_access(0, 32'h10, 1'b0, 2'b10, 32'h0);
        do_access(1, 32'h12, 1'b0, 2'b01, 32'h0);
        do_access(1, 32'h13, 1'b0, 2'b00, 32'h0);
    endtask

    task automatic test_misaligned();
        do_access(0, 32'h20, 1'b1, 2'b10, 32'hCAFEF00D);
        do_access(0, 32'h21, 1'b1, 2'b01, 32'h12345678);
        do_access(1, 32'h22, 1'b1, 2'b11, 32'h12345678);
        do_access(0, 32'h20, 1'b0, 2'b10, 32'h0);
    endtask

    task automatic test_out_of_range();
        do_access(1, 32'h100, 1'b1, 2'b10, 32'hA5A5A5A5);
        do_access(0, 32'h100, 1'b0, 2'b00, 32'h0);
        do_access(0, 32'hFC, 1'b1, 2'b10, 32'h5A5A5A5A);
        do_access(1, 32'hFC, 1'b0, 2'b10, 32'h0);
    endtask

    task automatic test_round_robin();
        test_reset();
        ADDR0 = 32'h0; WE0 = 1'b0; LEN0 = 2'b10;
        ADDR1 = 32'h4; WE1 = 1'b0; LEN1 = 2'b10;
        REQ0 = 1'b1;
        REQ1 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            logic [1:0] eg;
            logic [1:0] ev;
            @(posedge CLK);
            #1;
            eg = (i == 1 || i == 7) ? 2'b01 : (i == 4 || i == 10) ? 2'b10 : 2'b00;
            ev = (i == 2 || i == 8) ? 2'b01 : (i == 5 || i == 11) ? 2'b10 : 2'b00;
            tests++;
            if ({GNT1, GNT0} !== eg || {RVALID1, RVALID0} !== ev) begin
                fails++;
                $display("FAIL rr cycle %0d gnt=%b rvalid=%b want %b %b",
                         i, {GNT1, GNT0}, {RVALID1, RVALID0}, eg, ev);
            end
            if (i == 11) drop_reqs();
        end
    endtask

    task automatic test_fixed_prio();
        test_reset();
        ADDR0 = 32'h0; WE0 = 1'b0; LEN0 = 2'b10;
        ADDR1 = 32'h4; WE1 = 1'b0; LEN1 = 2'b10;
        REQ0 = 1'b1;
        REQ1 = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            logic [1:0] eg;
            @(posedge CLK);
            #1;
            eg = (i == 1 || i == 4 || i == 7 || i == 10) ? 2'b01 :
                 (i == 13) ? 2'b10 : 2'b00;
            tests++;
            if ({fp_gnt1, fp_gnt0} !== eg) begin
                fails++;
                $display("FAIL fixed_prio cycle %0d gnt=%b want %b", i, {fp_gnt1, fp_gnt0}, eg);
            end
            if (i == 11) REQ0 = 1'b0;
        end
        drop_reqs();
        test_reset();
    endtask

    task automatic test_random();
        for (int n = 0; n < 32; n++) begin
            int          port;
            logic [31:0] addr;
            logic        we;
            logic [1:0]  len;
            port = int'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, 32'h11F));
            we   = 1'($urandom_range(0, 1));
            len  = 2'($urandom_range(0, 3));
            do_access(port, addr, we, len, $urandom);
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        do_access(0, 32'h30, 1'b1, 2'b10, 32'h11111111);
        c0 = we_cnt;
        REQ1 = 1'b1; ADDR1 = 32'h30; WE1 = 1'b1; LEN1 = 2'b10; WDATA1 = 32'h22222222;
        @(posedge CLK);
        #1;
        tests++;
        if (MEM_WE !== 1'b1 || GNT1 !== 1'b1) begin
            fails++;
            $display("FAIL mid_issue we=%b gnt1=%b want 1 1", MEM_WE, GNT1);
        end
        #2;
        RST_N = 1'b0;
        #1;
        tests++;
        if (MEM_WE !== 1'b0 || GNT1 !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset we=%b gnt1=%b want 0 0", MEM_WE, GNT1);
        end
        REQ1 = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        tests++;
        if (we_cnt != c0) begin
            fails++;
            $display("FAIL mid_we_pulses got %0d want 0", we_cnt - c0);
        end
        ADDR0 = 32'h0; WE0 = 1'b0; LEN0 = 2'b10;
        ADDR1 = 32'h4; WE1 = 1'b0; LEN1 = 2'b10;
        REQ0 = 1'b1;
        REQ1 = 1'b1;
        @(posedge CLK);
        #1;
        tests++;
        if ({GNT1, GNT0} !== 2'b01) begin
            fails++;
            $display("FAIL tie_after_reset gnt=%b want 01", {GNT1, GNT0});
        end
        drop_reqs();
        repeat (2) @(posedge CLK);
        #1;
        do_access(0, 32'h30, 1'b0, 2'b10, 32'h0);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        we_cnt  = 0;
        mem_clr = 1'b1;
        RST_N   = 1'b0;
        REQ0 = 1'b0; ADDR0 = '0; WE0 = 1'b0; LEN0 = '0; WDATA0 = '0;
        REQ1 = 1'b0; ADDR1 = '0; WE1 = 1'b0; LEN1 = '0; WDATA1 = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        test_reset();
        mem_clr = 1'b0;
        test_store_load();
        test_misaligned();
        test_out_of_range();
        test_round_robin();
        test_fixed_prio();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port synchronous data memory.
- The memory has one-cycle read latency; both read and write act on the CLK edge.
- Port 0 is the core load/store unit. Port 1 is the loader/debug requester.
- The block serialises accesses, checks alignment and range, issues one memory operation per grant, and returns read data or a write acknowledgement to the owning port.

Parameters:
- MEM_WORDS, 64: number of 32-bit words in the memory. A legal word index is A[31:2] < MEM_WORDS.
- FIXED_PRIO, 0: 0 selects round-robin arbitration; 1 gives port 0 absolute priority.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ0 / REQ1  in  1  access request. Must be held until GNTx is seen.
- ADDR0 / ADDR1  in  32  byte address.
- WE0 / WE1  in  1  1 = store, 0 = load.
- LEN0 / LEN1  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = word.
- WDATA0 / WDATA1  in  32  store data.
- GNT0 / GNT1  out  1  one-cycle pulse: request accepted.
- RVALID0 / RVALID1  out  1  one-cycle pulse: response valid.
- RDATA  out  32  load data (already sign-extended by memory). 0 for stores and errors.
- RERR  out  1  qualifies RVALIDx: the access was rejected.
- MEM_A  out  32  memory address.
- MEM_WE  out  1  memory write enable.
- MEM_LEN  out  2  memory DATA_LENGTH.
- MEM_WD  out  32  memory write data.
- MEM_RD  in  32  memory read data, valid the cycle after MEM_A is presented.

Behaviour:

Reset (RST_N low, asynchronous):
- state = IDLE; last_owner = 1, so port 0 wins the first tie.
- All GNT, RVALID, RERR and MEM_WE outputs = 0; RDATA = 0.
- MEM_A, MEM_LEN, MEM_WD = 0.
- Reset during ISSUE drops MEM_WE immediately. No write may commit on the next edge.

FSM states: IDLE, ISSUE, RESP.

IDLE:
- If REQ0 or REQ1 is high, choose a winner:
  - FIXED_PRIO=1: port 0 wins whenever REQ0 is high.
  - Round-robin: if both request, the port that is not last_owner wins.
- Latch ADDR, WE, LEN and WDATA of the winner into owner registers.
- Compute err:
  - LEN=01 with A[0]=1 → err.
  - LEN=10 or 11 with A[1:0]≠0 → err.
  - A[31:2] ≥ MEM_WORDS → err.
- Update last_owner to the winner. Go to ISSUE.
- No request: stay in IDLE.

ISSUE (exactly 1 cycle):
- GNTx = 1 for the owner only.
- MEM_A, MEM_LEN and MEM_WD are driven from the latched values.
- MEM_WE = latched WE & ~err.
- An erroring store never reaches memory.
- Go to RESP.

RESP (exactly 1 cycle):
- RVALIDx = 1 for the owner.
- RDATA = MEM_RD if the access was a load and had no error; otherwise 0.
- RERR = err.
- Go to IDLE.

Timing and throughput:
- Request accepted in IDLE at edge N. GNT is high during cycle N+1. RVALID is high during cycle N+2.
- One access per 3 cycles.
- A request still high in the RESP cycle can be granted from the next IDLE evaluation.
- The requester must drop or change REQ after GNT. A REQ still high in IDLE is treated as a new request.

Output hygiene:
- Outside ISSUE, MEM_WE = 0. MEM_A, MEM_LEN and MEM_WD hold their last values.
- GNTx, RVALIDx and RERR are 0 in every non-owner case.
- GNT0 and GNT1 are never high together; the same holds for RVALID0 and RVALID1.

Request handling:
- A REQ withdrawn before it is sampled in IDLE is ignored.
- Request inputs are not sampled in ISSUE or RESP.
- A back-to-back requester is delayed by at most one access of the other port in round-robin mode.
- In FIXED_PRIO mode, port 1 may starve; this is accepted.

Test Plan:
- Store then load, port 0: store ADDR0=0x10, LEN=10, WDATA0=0xDEADBEEF, then load the same address. Required: GNT0 on the cycle after the request and RVALID0 one cycle later; the load returns RDATA=0xDEADBEEF with RERR=0; MEM_WE is high for exactly 1 cycle.
- Simultaneous requests, round-robin, after reset: REQ0 and REQ1 both held. Required grants in the order 0, 1, 0, 1, spaced 3 cycles apart.
- Simultaneous requests, FIXED_PRIO=1: REQ0 and REQ1 held for 4 accesses. Required: only GNT0 pulses; GNT1 first pulses after REQ0 drops.
- Misaligned store: LEN=01, ADDR=0x21. Required: RERR=1 and RDATA=0; MEM_WE stays 0; a later word load at 0x20 returns the old contents.
- Out-of-range store: ADDR=0x100 (word index 64). Required: RERR=1 and no memory write.
- Reset mid-access: pull RST_N low during a store's ISSUE cycle. Required: MEM_WE falls at once; the memory word is unchanged; after release, the FSM is in IDLE and port 0 wins the first tie.
